sc_fifo_flags: RTL and testbench



---
 rtl/sc_fifo_flags.sv | 118 +++++++++++
 tb/tb_sc_fifo_flags.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sc_fifo_flags.sv
// Single-clock FIFO with a register-array memory, exact fill count and registered flags.
// Optional sticky overflow/underflow detection is built only when SC_FIFO_FLAGS_ERR_EN is defined.
module sc_fifo_flags #(
  parameter int unsigned DWIDTH             = 8,
  parameter int unsigned AWIDTH             = 4,
  parameter int unsigned SHOWAHEAD          = 0,
  parameter int unsigned ALMOST_FULL_VALUE  = 2**AWIDTH - 2,
  parameter int unsigned ALMOST_EMPTY_VALUE = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int unsigned     DEPTH   = 2**AWIDTH;
  localparam logic [AWIDTH:0] CNT_MAX = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] CNT_ONE = (AWIDTH+1)'(1);
  localparam logic [AWIDTH:0] AF_TH   = (AWIDTH+1)'(ALMOST_FULL_VALUE);
  localparam logic [AWIDTH:0] AE_TH   = (AWIDTH+1)'(ALMOST_EMPTY_VALUE);
  localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [AWIDTH:0]   count_q, count_d;
  logic              empty_q, full_q, afull_q, aempty_q;
  logic              wr_acc, rd_acc;

  // Acceptance uses registered flags only, so a full FIFO drops a write even when a read frees a slot.
  always_comb begin
    wr_acc  = wrreq_i & ~full_q;
    rd_acc  = rdreq_i & ~empty_q;
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i && wr_acc) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == CNT_MAX);
      afull_q  <= (count_d >= AF_TH);
      aempty_q <= (count_d < AE_TH);
    end
  end

  generate
    if (SHOWAHEAD != 0) begin : g_show
      assign q_o = mem_q[rd_ptr_q];
    end else begin : g_norm
      logic [DWIDTH-1:0] q_q;
      always_ff @(posedge clk_i) begin
        if (srst_i) begin
          q_q <= '0;
        end else if (rd_acc) begin
          q_q <= mem_q[rd_ptr_q];
        end
      end
      assign q_o = q_q;
    end
  endgenerate

`ifdef SC_FIFO_FLAGS_ERR_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wrreq_i && full_q)  ovf_q <= 1'b1;
      if (rdreq_i && empty_q) unf_q <= 1'b1;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign usedw_o        = count_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;

endmodule

// File: tb/tb_sc_fifo_flags.sv
// Directed bench for sc_fifo_flags: a normal-mode and a show-ahead instance with a 4-deep FIFO.
module tb_sc_fifo_flags;

`ifdef SC_FIFO_FLAGS_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       srst;
  logic [7:0] d, d2;
  logic       wr, rd, wr2, rd2;
  logic [7:0] q, q2;
  logic       empty, full, af, ae, ovf, unf;
  logic       empty2, full2, af2, ae2, ovf2, unf2;
  logic [2:0] usedw, usedw2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sc_fifo_flags #(
    .DWIDTH(8), .AWIDTH(2), .SHOWAHEAD(0), .ALMOST_FULL_VALUE(3), .ALMOST_EMPTY_VALUE(1)
  ) dut (
    .clk_i(clk), .srst_i(srst), .data_i(d), .wrreq_i(wr), .rdreq_i(rd),
    .q_o(q), .empty_o(empty), .full_o(full), .usedw_o(usedw),
    .almost_full_o(af), .almost_empty_o(ae), .overflow_o(ovf), .underflow_o(unf)
  );

  sc_fifo_flags #(
    .DWIDTH(8), .AWIDTH(2), .SHOWAHEAD(1), .ALMOST_FULL_VALUE(3), .ALMOST_EMPTY_VALUE(1)
  ) dut_sa (
    .clk_i(clk), .srst_i(srst), .data_i(d2), .wrreq_i(wr2), .rdreq_i(rd2),
    .q_o(q2), .empty_o(empty2), .full_o(full2), .usedw_o(usedw2),
    .almost_full_o(af2), .almost_empty_o(ae2), .overflow_o(ovf2), .underflow_o(unf2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    srst = 1'b1; wr = 1'b0; rd = 1'b0; d = '0;
    wr2 = 1'b0; rd2 = 1'b0; d2 = '0;
    step(); step();
    srst = 1'b0;

    // Reset state
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_usedw", usedw, 0);
    chk("rst_ae", ae, 1);
    chk("rst_af", af, 0);
    chk("rst_q", q, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    chk("rst_sa_empty", empty2, 1);

    // Fill
    wr = 1'b1; d = 8'h11; step();
    chk("w1_usedw", usedw, 1); chk("w1_empty", empty, 0); chk("w1_af", af, 0); chk("w1_ae", ae, 0);
    d = 8'h22; step();
    chk("w2_usedw", usedw, 2); chk("w2_af", af, 0);
    d = 8'h33; step();
    chk("w3_usedw", usedw, 3); chk("w3_af", af, 1); chk("w3_full", full, 0);
    d = 8'h44; step();
    chk("w4_usedw", usedw, 4); chk("w4_full", full, 1); chk("w4_af", af, 1);
    d = 8'h55; step();
    chk("w5_usedw", usedw, 4); chk("w5_full", full, 1); chk("w5_ovf", ovf, EXP_ERR);
    wr = 1'b0;

    // Drain
    rd = 1'b1; step();
    chk("r1_q", q, 8'h11); chk("r1_usedw", usedw, 3); chk("r1_full", full, 0);
    step();
    chk("r2_q", q, 8'h22); chk("r2_usedw", usedw, 2); chk("r2_af", af, 0);
    step();
    chk("r3_q", q, 8'h33); chk("r3_usedw", usedw, 1);
    step();
    chk("r4_q", q, 8'h44); chk("r4_usedw", usedw, 0); chk("r4_empty", empty, 1); chk("r4_ae", ae, 1);
    chk("r4_unf", unf, 0);
    step();
    chk("r5_q", q, 8'h44); chk("r5_usedw", usedw, 0); chk("r5_unf", unf, EXP_ERR);
    rd = 1'b0;

    // Simultaneous read/write with pointer wrap
    wr = 1'b1; d = 8'h01; step();
    d = 8'h02; step();
    chk("rw_pre_usedw", usedw, 2);
    rd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = 8'(8'h03 + i);
      step();
      chk($sformatf("rw%0d_q", i), q, 32'(8'h01 + i));
      chk($sformatf("rw%0d_usedw", i), usedw, 2);
    end
    wr = 1'b0; step();
    chk("rw_tail1_q", q, 8'h07); chk("rw_tail1_usedw", usedw, 1);
    step();
    chk("rw_tail2_q", q, 8'h08); chk("rw_tail2_empty", empty, 1);
    rd = 1'b0;

    // Show-ahead instance
    wr2 = 1'b1; d2 = 8'hA5; step();
    chk("sa_w_q", q2, 8'hA5); chk("sa_w_empty", empty2, 0); chk("sa_w_usedw", usedw2, 1);
    wr2 = 1'b0; rd2 = 1'b1; step();
    chk("sa_r_empty", empty2, 1); chk("sa_r_usedw", usedw2, 0);
    rd2 = 1'b0; wr2 = 1'b1;
    d2 = 8'hB1; step();
    chk("sa_b1_q", q2, 8'hB1);
    d2 = 8'hB2; step();
    d2 = 8'hB3; step();
    d2 = 8'hB4; step();
    chk("sa_full", full2, 1); chk("sa_full_q", q2, 8'hB1);
    d2 = 8'hC5; rd2 = 1'b1; step();
    chk("sa_wf_usedw", usedw2, 3); chk("sa_wf_full", full2, 0); chk("sa_wf_q", q2, 8'hB2);
    chk("sa_wf_ovf", ovf2, EXP_ERR);
    wr2 = 1'b0; step();
    chk("sa_d1_q", q2, 8'hB3); chk("sa_d1_usedw", usedw2, 2);
    step();
    chk("sa_d2_q", q2, 8'hB4); chk("sa_d2_usedw", usedw2, 1);
    step();
    chk("sa_d3_empty", empty2, 1); chk("sa_d3_usedw", usedw2, 0);
    rd2 = 1'b0;

    // Mid-operation reset with a concurrent write
    wr = 1'b1;
    d = 8'h61; step();
    d = 8'h62; step();
    d = 8'h63; step();
    chk("pre_rst_usedw", usedw, 3);
    srst = 1'b1; d = 8'h77; step();
    chk("mrst_usedw", usedw, 0); chk("mrst_empty", empty, 1); chk("mrst_full", full, 0);
    chk("mrst_af", af, 0); chk("mrst_ae", ae, 1); chk("mrst_q", q, 0);
    chk("mrst_ovf", ovf, 0); chk("mrst_unf", unf, 0);
    chk("mrst_sa_ovf", ovf2, 0);
    srst = 1'b0; wr = 1'b0; step();
    chk("post_rst_usedw", usedw, 0); chk("post_rst_empty", empty, 1);
    wr = 1'b1; d = 8'h88; step();
    wr = 1'b0; rd = 1'b1; step();
    chk("post_rst_q", q, 8'h88); chk("post_rst_empty2", empty, 1);
    rd = 1'b0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
